ssd_scan_driver: RTL

Parametrised multi-digit seven-segment scan driver for the board display path. Accepts an unsigned binary value over a valid/ready handshake, converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes N_DIGITS common-anode digits with a programmable refresh rate. Adds optional leading-zero blanking, overflow indication, and optional signed display. It sits between the processor's debug/output register and the board's anode/segment pins.

---
 rtl/ssd_pkg.sv | 43 ++++
 rtl/ssd_scan_driver_bin2bcd_seq.sv | 128 ++++++++++++
 rtl/ssd_scan_driver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: segment codes, converter states, helpers.
// SSD_SIGNED_EN (optional) enables the minus-sign display path in the modules importing this.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } conv_state_e;

    // Active-low pattern, seg[6]=a ... seg[0]=g.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with valid/ready intake and overflow compare.
// SSD_SIGNED_EN: input is two's complement; converts |num| and reports the sign.
module bin2bcd_seq #(
    parameter int unsigned NUM_W    = 14,
    parameter int unsigned N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  num_valid_i,
    output logic                  num_ready_o,
    input  logic [NUM_W-1:0]      num_i,
    input  logic                  blank_lz_i,
    output logic                  commit_o,
    output logic [4*N_DIGITS-1:0] bcd_o,
    output logic                  blank_lz_o,
`ifdef SSD_SIGNED_EN
    output logic                  neg_o,
`endif
    output logic                  ovf_o
);
    import ssd_pkg::*;

    localparam int unsigned BCD_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = $clog2(NUM_W);
    localparam logic [63:0] LIMIT = pow10(N_DIGITS);

    conv_state_e      state_q, state_d;
    logic [NUM_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lz_q, lz_d;
    logic             ovf_q, ovf_d;
    logic [NUM_W-1:0] mag;
    logic             ovf_in;
`ifdef SSD_SIGNED_EN
    localparam logic [63:0] LIMIT_NEG = pow10(N_DIGITS - 1);
    logic neg_q, neg_d, neg_in;
`endif

    always_comb begin
`ifdef SSD_SIGNED_EN
        neg_in = num_i[NUM_W-1];
        mag    = neg_in ? (~num_i + 1'b1) : num_i;
        // A negative value gives up its leftmost digit to the minus sign.
        ovf_in = neg_in ? ((64'(mag) >= LIMIT_NEG) || mag[NUM_W-1]) : (64'(mag) >= LIMIT);
`else
        mag    = num_i;
        ovf_in = 64'(num_i) >= LIMIT;
`endif

        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        lz_d        = lz_q;
        ovf_d       = ovf_q;
`ifdef SSD_SIGNED_EN
        neg_d       = neg_q;
`endif
        num_ready_o = 1'b0;
        commit_o    = 1'b0;

        adj = bcd_q;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        unique case (state_q)
            StIdle: begin
                num_ready_o = 1'b1;
                if (num_valid_i) begin
                    bin_d   = mag;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    lz_d    = blank_lz_i;
                    ovf_d   = ovf_in;
`ifdef SSD_SIGNED_EN
                    neg_d   = neg_in;
`endif
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = {adj[BCD_W-2:0], bin_q[NUM_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_W - 1)) state_d = StCommit;
            end
            StCommit: begin
                commit_o = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            lz_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SSD_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            lz_q    <= lz_d;
            ovf_q   <= ovf_d;
`ifdef SSD_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign bcd_o      = bcd_q;
    assign blank_lz_o = lz_q;
    assign ovf_o      = ovf_q;
`ifdef SSD_SIGNED_EN
    assign neg_o      = neg_q;
`endif

endmodule

// File: rtl/ssd_scan_driver.sv
// Multi-digit seven-segment scan driver: shadow display registers, blanking, refresh scan.
// SSD_SIGNED_EN: adds a minus digit for negative two's-complement inputs.
module ssd_scan_driver #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned NUM_W       = 14,
    parameter int unsigned REFRESH_DIV = 262144
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                num_valid,
    output logic                num_ready,
    input  logic [NUM_W-1:0]    num,
    input  logic                blank_lz,
    output logic [N_DIGITS-1:0] anode,
    output logic [6:0]          seg,
    output logic                overflow
);
    import ssd_pkg::*;

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam int unsigned BCD_W = 4 * N_DIGITS;

    logic             commit;
    logic [BCD_W-1:0] bcd;
    logic             conv_lz;
    logic             conv_ovf;
`ifdef SSD_SIGNED_EN
    logic                conv_neg;
    logic [N_DIGITS-1:0] minus_q, minus_d, minus_new;
`endif

    bin2bcd_seq #(
        .NUM_W    (NUM_W),
        .N_DIGITS (N_DIGITS)
    ) u_conv (
        .clk         (clk),
        .rst         (rst),
        .num_valid_i (num_valid),
        .num_ready_o (num_ready),
        .num_i       (num),
        .blank_lz_i  (blank_lz),
        .commit_o    (commit),
        .bcd_o       (bcd),
        .blank_lz_o  (conv_lz),
`ifdef SSD_SIGNED_EN
        .neg_o       (conv_neg),
`endif
        .ovf_o       (conv_ovf)
    );

    logic [BCD_W-1:0]    dig_q, dig_d;
    logic [N_DIGITS-1:0] blank_q, blank_d, blank_new;
    logic                ovf_q, ovf_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;

    always_comb begin
        logic lead;
        dig_d   = dig_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;

        // Zeros stay blanked until the first nonzero digit from the left; digit 0 never blanks.
        lead      = conv_lz;
        blank_new = '0;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            if (bcd[4*i +: 4] != 4'd0) lead = 1'b0;
            blank_new[i] = lead;
        end
`ifdef SSD_SIGNED_EN
        minus_d   = minus_q;
        minus_new = '0;
        for (int i = 1; i < int'(N_DIGITS); i++) begin
            minus_new[i] = conv_neg && !blank_new[i-1] &&
                           (blank_new[i] || (i == int'(N_DIGITS) - 1));
        end
        blank_new = blank_new & ~minus_new;
`endif

        if (commit) begin
            dig_d   = bcd;
            blank_d = blank_new;
            ovf_d   = conv_ovf;
`ifdef SSD_SIGNED_EN
            minus_d = minus_new;
`endif
        end

        if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == '0) ? IDX_W'(N_DIGITS - 1) : idx_q - 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
            idx_d = idx_q;
        end

        anode_d = ~(N_DIGITS'(1) << idx_q);
        seg_d   = bcd_to_seg(dig_q[4*int'(idx_q) +: 4]);
        if (blank_q[idx_q]) seg_d = SEG_BLANK;
`ifdef SSD_SIGNED_EN
        if (minus_q[idx_q]) seg_d = SEG_MINUS;
`endif
        if (ovf_q) seg_d = SEG_DASH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q   <= '0;
            blank_q <= '0;
            ovf_q   <= 1'b0;
`ifdef SSD_SIGNED_EN
            minus_q <= '0;
`endif
            pre_q   <= '0;
            idx_q   <= IDX_W'(N_DIGITS - 1);
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            dig_q   <= dig_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
`ifdef SSD_SIGNED_EN
            minus_q <= minus_d;
`endif
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign anode    = anode_q;
    assign seg      = seg_q;
    assign overflow = ovf_q;

endmodule
